// File: rtl/hazard_pattern_decoder.sv
// -----------------------------------------------------------------------------
// hazard_pattern_decoder
//
// Receive side of the flight-line hazard-light link. Samples the 3-bit lamp
// pattern driven by the hazard-light display ({left, centre, right}), recovers
// the wind mode from the sequence of display steps and flags illegal steps.
//
// Wind encoding: 00 calm, 01 right-to-left, 10 left-to-right (11 never driven).
//
// Legal step classes (prev -> cur):
//   calm : 101->010, 010->101
//   R->L : 001->010, 010->100, 100->001
//   L->R : 100->010, 010->001, 001->100
//
// Parameters:
//   LOCK_COUNT  consecutive same-class legal transitions needed to lock
//   TIMEOUT     clk cycles without sample_en before lock is dropped (>=2)
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   reset      in   synchronous, active-low reset
//   sample_en  in   one-cycle strobe: pattern holds a new display step
//   pattern    in   3-bit lamp pattern {left, centre, right}
//   wind       out  decoded wind mode, held across loss of lock
//   valid      out  wind is locked and trustworthy
//   err        out  one-cycle pulse on an illegal transition
//   err_count  out  saturating illegal-transition count
//
// Optional feature macro: HAZARD_DECODE_STATS_EN
//   defined     -> err_count counts err pulses, saturating at 255
//   not defined -> err_count is tied to zero, no counter is built
// -----------------------------------------------------------------------------
module hazard_pattern_decoder #(
  parameter int LOCK_COUNT = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic [2:0] pattern,
  output logic [1:0] wind,
  output logic       valid,
  output logic       err,
  output logic [7:0] err_count
);

  localparam int CNT_W = $clog2(LOCK_COUNT + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);

  localparam logic [1:0] CLS_CALM = 2'b00;
  localparam logic [1:0] CLS_RL   = 2'b01;
  localparam logic [1:0] CLS_LR   = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // One of the four patterns the display can legally show.
  function automatic logic is_lamp(input logic [2:0] p);
    return (p == 3'b101) || (p == 3'b010) || (p == 3'b100) || (p == 3'b001);
  endfunction

  // Returns {legal, class}. Repeats and any non-lamp step fall to default.
  function automatic logic [2:0] classify(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] res;
    case ({a, b})
      6'b101_010, 6'b010_101:             res = {1'b1, CLS_CALM};
      6'b001_010, 6'b010_100, 6'b100_001: res = {1'b1, CLS_RL};
      6'b100_010, 6'b010_001, 6'b001_100: res = {1'b1, CLS_LR};
      default:                            res = 3'b000;
    endcase
    return res;
  endfunction

  state_t           state, state_n;
  logic [2:0]       prev, prev_n;
  logic [1:0]       cls, cls_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [TO_W-1:0]  tcnt, tcnt_n;
  logic [1:0]       wind_n;
  logic             valid_n;
  logic             err_n;
  logic [2:0]       tr;
  logic             tr_legal;
  logic [1:0]       tr_cls;

  assign tr       = classify(prev, pattern);
  assign tr_legal = tr[2];
  assign tr_cls   = tr[1:0];
  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  // Next-state / output decode
  always_comb begin
    state_n = state;
    prev_n  = prev;
    cls_n   = cls;
    cnt_n   = cnt;
    wind_n  = wind;
    valid_n = valid;
    err_n   = 1'b0;
    tcnt_n  = sample_en ? '0 : ((tcnt == TO_MAX) ? tcnt : tcnt + TO_ONE);

    if (sample_en) begin
      prev_n = pattern;
      case (state)
        IDLE: begin
          if (is_lamp(pattern)) begin
            state_n = ACQUIRE;
            cnt_n   = '0;
          end else begin
            err_n = 1'b1;
          end
        end
        ACQUIRE, LOCKED: begin
          if (tr_legal) begin
            // A run of one class starts at 1 whenever the class changes;
            // after an illegal step cnt is 0 so either branch yields 1.
            if (tr_cls == cls) begin
              cnt_n = cnt_inc;
            end else begin
              cls_n = tr_cls;
              cnt_n = CNT_ONE;
            end
            if ((state == LOCKED) && (tr_cls != cls)) begin
              state_n = ACQUIRE;
              valid_n = 1'b0;
            end else if (cnt_n == CNT_MAX) begin
              state_n = LOCKED;
              wind_n  = cls_n;
              valid_n = 1'b1;
            end
          end else begin
            err_n   = 1'b1;
            cnt_n   = '0;
            valid_n = 1'b0;
            state_n = is_lamp(pattern) ? ACQUIRE : IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          valid_n = 1'b0;
        end
      endcase
    end else if ((tcnt_n == TO_MAX) && (state != IDLE)) begin
      // Display went quiet: drop lock but keep the last wind reading.
      state_n = IDLE;
      valid_n = 1'b0;
      cnt_n   = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      prev  <= 3'b000;
      cls   <= CLS_CALM;
      cnt   <= '0;
      tcnt  <= '0;
      wind  <= 2'b00;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      prev  <= prev_n;
      cls   <= cls_n;
      cnt   <= cnt_n;
      tcnt  <= tcnt_n;
      wind  <= wind_n;
      valid <= valid_n;
      err   <= err_n;
    end
  end

`ifdef HAZARD_DECODE_STATS_EN
  // Counts in step with the err register so both update on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_count <= 8'd0;
    end else if (err_n && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_hazard_pattern_decoder.sv
module tb_hazard_pattern_decoder;

  localparam int LOCK_COUNT = 3;
  localparam int TIMEOUT    = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_en = 1'b0;
  logic [2:0] pattern = 3'b000;
  logic [1:0] wind;
  logic       valid;
  logic       err;
  logic [7:0] err_count;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  hazard_pattern_decoder #(
    .LOCK_COUNT(LOCK_COUNT),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sample_en(sample_en),
    .pattern  (pattern),
    .wind     (wind),
    .valid    (valid),
    .err      (err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s/%s: got=%0d expected=%0d", phase, tag, got, exp);
    end
  endtask

  // Legal transition table: pair_a -> pair_b belongs to class pair_c.
  logic [2:0] pair_a [8] = '{3'b101, 3'b010, 3'b001, 3'b010, 3'b100, 3'b100, 3'b010, 3'b001};
  logic [2:0] pair_b [8] = '{3'b010, 3'b101, 3'b010, 3'b100, 3'b001, 3'b010, 3'b001, 3'b100};
  int         pair_c [8] = '{0, 0, 1, 1, 1, 2, 2, 2};

  function automatic int pair_class(input logic [2:0] a, input logic [2:0] b);
    for (int i = 0; i < 8; i++)
      if (pair_a[i] == a && pair_b[i] == b) return pair_c[i];
    return -1;
  endfunction

  function automatic bit lamp(input logic [2:0] p);
    return (p == 3'b101) || (p == 3'b010) || (p == 3'b100) || (p == 3'b001);
  endfunction

  function automatic logic [2:0] pick_next(input logic [2:0] a, input int pref);
    for (int i = 0; i < 8; i++)
      if (pair_a[i] == a && pair_c[i] == pref) return pair_b[i];
    for (int i = 0; i < 8; i++)
      if (pair_a[i] == a) return pair_b[i];
    return 3'b010;
  endfunction

  // Reference model: mode 0 = idle, 1 = hunting for a run, 2 = locked.
  int m_mode, m_prev, m_run, m_rcls, m_idle;
  int m_wind, m_valid, m_err, m_errcnt;

  task automatic model_update(input logic en, input logic [2:0] pat, input logic rn);
    int c;
    if (!rn) begin
      m_mode = 0; m_prev = 0; m_run = 0; m_rcls = 0; m_idle = 0;
      m_wind = 0; m_valid = 0; m_err = 0; m_errcnt = 0;
      return;
    end
    m_err = 0;
    if (en) begin
      m_idle = 0;
      if (m_mode == 0) begin
        if (lamp(pat)) begin m_mode = 1; m_run = 0; end
        else m_err = 1;
      end else begin
        c = pair_class(3'(m_prev), pat);
        if (c < 0) begin
          m_err = 1; m_run = 0; m_valid = 0;
          m_mode = lamp(pat) ? 1 : 0;
        end else if (m_mode == 2 && c != m_rcls) begin
          m_mode = 1; m_rcls = c; m_run = 1; m_valid = 0;
        end else begin
          if (m_run > 0 && c == m_rcls) m_run = (m_run < LOCK_COUNT) ? m_run + 1 : LOCK_COUNT;
          else begin m_rcls = c; m_run = 1; end
          if (m_run == LOCK_COUNT) begin m_mode = 2; m_wind = c; m_valid = 1; end
        end
      end
      m_prev = int'(pat);
    end else begin
      if (m_idle < TIMEOUT) m_idle++;
      if (m_idle == TIMEOUT && m_mode != 0) begin
        m_mode = 0; m_valid = 0; m_run = 0;
      end
    end
`ifdef HAZARD_DECODE_STATS_EN
    if (m_err == 1 && m_errcnt < 255) m_errcnt++;
`endif
  endtask

  task automatic step(input logic en, input logic [2:0] pat, input logic rn);
    @(negedge clk);
    sample_en = en;
    pattern   = pat;
    reset     = rn;
    @(posedge clk);
    model_update(en, pat, rn);
    #1;
    check_eq("wind", int'(wind), m_wind);
    check_eq("valid", int'(valid), m_valid);
    check_eq("err", int'(err), m_err);
    check_eq("err_count", int'(err_count), m_errcnt);
  endtask

  int         r, g, pref;
  logic       en_r;
  logic [2:0] p_r, last_pat;

  initial begin
    // Reset state
    phase = "reset";
    step(1'b0, 3'b000, 1'b0);
    step(1'b1, 3'b101, 1'b0);
    check_eq("reset_valid", int'(valid), 0);
    check_eq("reset_wind", int'(wind), 0);

    // Calm lock after three transitions
    phase = "calm_lock";
    step(1'b1, 3'b101, 1'b1);
    step(1'b1, 3'b010, 1'b1);
    step(1'b1, 3'b101, 1'b1);
    check_eq("pre_lock_valid", int'(valid), 0);
    step(1'b1, 3'b010, 1'b1);
    check_eq("lock_valid", int'(valid), 1);
    check_eq("lock_wind", int'(wind), 0);

    // Right-to-left lock, stay, then class change drops valid
    phase = "rl_lock";
    step(1'b1, 3'b001, 1'b1);
    step(1'b1, 3'b010, 1'b1);
    step(1'b1, 3'b100, 1'b1);
    step(1'b1, 3'b001, 1'b1);
    check_eq("rl_wind", int'(wind), 1);
    check_eq("rl_valid", int'(valid), 1);
    step(1'b1, 3'b010, 1'b1);
    check_eq("rl_stay_valid", int'(valid), 1);
    step(1'b1, 3'b001, 1'b1);
    check_eq("rl_drop_valid", int'(valid), 0);
    check_eq("rl_drop_wind", int'(wind), 1);

    // Left-to-right lock then illegal 111
    phase = "lr_illegal";
    step(1'b1, 3'b100, 1'b1);
    step(1'b1, 3'b010, 1'b1);
    step(1'b1, 3'b001, 1'b1);
    step(1'b1, 3'b100, 1'b1);
    check_eq("lr_wind", int'(wind), 2);
    check_eq("lr_valid", int'(valid), 1);
    step(1'b1, 3'b111, 1'b1);
    check_eq("illegal_err", int'(err), 1);
    check_eq("illegal_valid", int'(valid), 0);
    step(1'b0, 3'b000, 1'b1);
    check_eq("err_one_cycle", int'(err), 0);

    // Timeout after lock
    phase = "timeout";
    step(1'b1, 3'b101, 1'b1);
    step(1'b1, 3'b010, 1'b1);
    step(1'b1, 3'b101, 1'b1);
    step(1'b1, 3'b010, 1'b1);
    check_eq("to_locked", int'(valid), 1);
    for (int k = 0; k < TIMEOUT - 1; k++) step(1'b0, 3'b000, 1'b1);
    check_eq("to_before_edge", int'(valid), 1);
    step(1'b0, 3'b000, 1'b1);
    check_eq("to_edge_valid", int'(valid), 0);
    check_eq("to_edge_wind", int'(wind), 0);
    step(1'b1, 3'b101, 1'b1);
    check_eq("to_restart_err", int'(err), 0);

    // Reset mid-lock
    phase = "reset_mid";
    step(1'b1, 3'b010, 1'b1);
    step(1'b1, 3'b101, 1'b1);
    step(1'b1, 3'b010, 1'b1);
    check_eq("mid_locked", int'(valid), 1);
    step(1'b1, 3'b101, 1'b0);
    check_eq("mid_valid", int'(valid), 0);
    check_eq("mid_wind", int'(wind), 0);
    step(1'b1, 3'b010, 1'b1);
    check_eq("mid_first_err", int'(err), 0);
    step(1'b1, 3'b101, 1'b1);

`ifdef HAZARD_DECODE_STATS_EN
    // Saturation of the illegal-transition counter
    phase = "saturate";
    step(1'b0, 3'b000, 1'b0);
    step(1'b1, 3'b101, 1'b1);
    for (int k = 0; k < 300; k++) step(1'b1, 3'b101, 1'b1);
    check_eq("sat_count", int'(err_count), 255);
`endif

    // Randomized traffic against the model
    phase    = "random";
    last_pat = 3'b101;
    pref     = 0;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 999);
      if (r < 5) begin
        step(1'b1, 3'($urandom), 1'b0);
      end else if (r < 12) begin
        g = $urandom_range(TIMEOUT - 6, TIMEOUT + 6);
        for (int k = 0; k < g; k++) step(1'b0, 3'($urandom), 1'b1);
      end else begin
        en_r = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 9) < 8) p_r = pick_next(last_pat, pref);
        else p_r = 3'($urandom);
        if ($urandom_range(0, 19) == 0) pref = $urandom_range(0, 2);
        step(en_r, p_r, 1'b1);
        if (en_r) last_pat = p_r;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
